// File: rtl/RS5_pkg.sv
// Shared types for the RS5 data-RAM arbiter: plugin FSM states and read tags.
package RS5_pkg;

    typedef enum logic [1:0] {P_IDLE, P_ACK, P_RD} plg_arb_state_e;

    // One bit per requester; marks which side owns a RAM read in flight.
    typedef struct packed {
        logic cpu;
        logic plg;
    } rd_tag_t;

    localparam logic [3:0] WE_WORD = 4'hF;
    localparam logic [3:0] WE_NONE = 4'h0;

endpackage

// File: rtl/plugin_rd_tag_pipe.sv
// RAM_LATENCY-deep shift register of read tags; the tag leaves the pipe in the
// same cycle the RAM presents the matching read data.
module plugin_rd_tag_pipe
    import RS5_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t tag_pipe [RAM_LATENCY];

    // Shift tags one stage per cycle; reset flushes anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[RAM_LATENCY-1];

endmodule

// File: rtl/plugin_mem_arbiter.sv
// Single-port data RAM arbiter between the RS5 CPU data port and the image
// plugin. CPU wins by default; a starvation counter forces a plugin grant.
// Optional macro PLUGIN_ADDR_CHECK_EN: plugin accesses outside the RAM window
// are not issued, complete with zero data and set a sticky plg_err_o.
module plugin_mem_arbiter
    import RS5_pkg::*;
#(
    parameter int          RAM_LATENCY  = 1,
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE     = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_enable_i,
    input  logic [3:0]  cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_stall_o,
    input  logic        plg_req_i,
    input  logic        plg_we_i,
    input  logic [31:0] plg_addr_i,
    input  logic [31:0] plg_wdata_i,
    output logic [31:0] plg_rdata_o,
    output logic        plg_ready_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        plg_err_o
);

    plg_arb_state_e state, state_nxt;
    logic [7:0]     starve_cnt;
    logic           plg_new, in_win, plg_bad, plg_cand, starved;
    logic           plg_gnt, cpu_gnt;
    logic [31:0]    plg_rdata_q;
    logic           plg_err_q;
    rd_tag_t        tag_in, tag_out;

    // A fresh plugin request is only looked at while idle; gated by reset so
    // nothing is granted or driven while reset_n is low.
    assign plg_new = reset_n && (state == P_IDLE) && plg_req_i;
    assign in_win  = (plg_addr_i >= RAM_BASE) && ((plg_addr_i - RAM_BASE) < RAM_SIZE);

`ifdef PLUGIN_ADDR_CHECK_EN
    assign plg_bad = plg_new && !in_win;
`else
    logic unused_win;
    assign unused_win = in_win;
    assign plg_bad    = 1'b0;
`endif

    assign plg_cand    = plg_new && !plg_bad;
    assign starved     = (starve_cnt == 8'(STARVE_LIMIT));
    assign plg_gnt     = plg_cand && (starved || !cpu_enable_i);
    assign cpu_gnt     = reset_n && cpu_enable_i && !plg_gnt;
    assign cpu_stall_o = reset_n && cpu_enable_i && plg_gnt;

    // Steer the granted requester onto the RAM port, same cycle.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = WE_NONE;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (cpu_gnt) begin
            ram_en_o   = 1'b1;
            ram_we_o   = cpu_we_i;
            ram_addr_o = cpu_addr_i;
            ram_data_o = cpu_data_i;
        end else if (plg_gnt) begin
            ram_en_o   = 1'b1;
            ram_we_o   = plg_we_i ? WE_WORD : WE_NONE;
            ram_addr_o = plg_addr_i;
            ram_data_o = plg_wdata_i;
        end
    end

    assign tag_in.cpu = cpu_gnt && (cpu_we_i == WE_NONE);
    assign tag_in.plg = plg_gnt && !plg_we_i;

    plugin_rd_tag_pipe #(.RAM_LATENCY(RAM_LATENCY)) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Plugin FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= P_IDLE;
        else          state <= state_nxt;
    end

    // Plugin FSM next state and completion pulse.
    always_comb begin
        state_nxt   = state;
        plg_ready_o = 1'b0;
        case (state)
            P_IDLE: begin
                if (plg_bad)      state_nxt = P_ACK;
                else if (plg_gnt) state_nxt = plg_we_i ? P_ACK : P_RD;
            end
            P_ACK: begin
                plg_ready_o = 1'b1;
                state_nxt   = P_IDLE;
            end
            P_RD: begin
                if (tag_out.plg) begin
                    plg_ready_o = 1'b1;
                    state_nxt   = P_IDLE;
                end
            end
            default: state_nxt = P_IDLE;
        endcase
    end

    // Count denied plugin cycles, saturating; any plugin completion path clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      starve_cnt <= '0;
        else if (plg_gnt || plg_bad)       starve_cnt <= '0;
        else if (plg_cand && !starved)     starve_cnt <= starve_cnt + 8'd1;
    end

    // Return read data to its owner; plugin data is also held for later cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_data_o  <= '0;
            plg_rdata_q <= '0;
            plg_err_q   <= 1'b0;
        end else begin
            if (tag_out.cpu) cpu_data_o  <= ram_data_i;
            if (tag_out.plg) plg_rdata_q <= ram_data_i;
            else if (plg_bad) plg_rdata_q <= '0;
            if (plg_bad)     plg_err_q   <= 1'b1;
        end
    end

    assign plg_rdata_o = tag_out.plg ? ram_data_i : plg_rdata_q;
    assign plg_err_o   = plg_err_q;

endmodule

// File: tb/tb_plugin_mem_arbiter.sv
// Directed bench for plugin_mem_arbiter with a behavioural latency-LAT RAM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_plugin_mem_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_enable;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_data_o;
    logic        cpu_stall_o;
    logic        plg_req, plg_we;
    logic [31:0] plg_addr, plg_wdata, plg_rdata_o;
    logic        plg_ready_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic        plg_err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    plugin_mem_arbiter #(.RAM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_enable_i (cpu_enable),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_data_i   (cpu_wdata),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .plg_req_i    (plg_req),
        .plg_we_i     (plg_we),
        .plg_addr_i   (plg_addr),
        .plg_wdata_i  (plg_wdata),
        .plg_rdata_o  (plg_rdata_o),
        .plg_ready_o  (plg_ready_o),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .ram_data_i   (ram_data_i),
        .plg_err_o    (plg_err_o)
    );

    // Unwritten words read back as a pattern derived from their word index.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA000_0000 | {18'd0, a[15:2]};
    endfunction

    // RAM model: 64KB, byte writes, read data appears LAT cycles after ram_en_o.
    logic [31:0] mem    [16384];
    bit          wr_vld [16384];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (ram_en_o) begin
            rd_pipe[0] <= wr_vld[ram_addr_o[15:2]] ? mem[ram_addr_o[15:2]] : pat(ram_addr_o);
            if (ram_we_o != 4'h0) begin
                logic [31:0] w;
                w = wr_vld[ram_addr_o[15:2]] ? mem[ram_addr_o[15:2]] : pat(ram_addr_o);
                for (int b = 0; b < 4; b++)
                    if (ram_we_o[b]) w[8*b +: 8] = ram_data_o[8*b +: 8];
                mem[ram_addr_o[15:2]]    <= w;
                wr_vld[ram_addr_o[15:2]] <= 1'b1;
            end
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_data_i = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic edge_in();
        @(posedge clk); #1;
    endtask

    // Plugin read with a bounded wait for plg_ready_o; lat = -1 on timeout.
    task automatic plg_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        edge_in();
        plg_req = 1'b1; plg_we = 1'b0; plg_addr = a;
        lat = -1; d = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (plg_ready_o) begin d = plg_rdata_o; lat = i; break; end
            edge_in();
        end
        edge_in();
        plg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat, stalls, rdy_seen;
        logic [31:0] orr;

        // Reset with both requesters asserting: everything must stay quiet.
        reset_n = 1'b0; cpu_enable = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h44; cpu_wdata = '0;
        plg_req = 1'b1; plg_we = 1'b0; plg_addr = 32'h48; plg_wdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ram_en", ram_en_o, 0);
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_outs", {ram_we_o, ram_addr_o | ram_data_o | cpu_data_o | plg_rdata_o,
                         plg_ready_o, plg_err_o}, 0);
        edge_in();
        reset_n = 1'b1; cpu_enable = 1'b0; plg_req = 1'b0;

        // CPU-only reads 0x100..0x124, back to back.
        stalls = 0;
        for (int k = 0; k < 10 + LAT + 1; k++) begin
            edge_in();
            cpu_enable = (k < 10); cpu_we = 4'h0; cpu_addr = 32'h100 + 32'(4 * k);
            @(negedge clk);
            stalls += int'(cpu_stall_o);
            if (k == 0) chk("cpu_ram_addr", ram_addr_o, 32'h100);
            if (k >= LAT + 1) chk("cpu_rd", cpu_data_o, pat(32'h100 + 32'(4 * (k - LAT - 1))));
        end
        chk("cpu_nostall", stalls, 0);

        // CPU partial write passes byte enables through.
        edge_in();
        cpu_enable = 1'b1; cpu_we = 4'b0011; cpu_addr = 32'h500; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("cpu_wr_we", ram_we_o, 4'b0011);
        chk("cpu_wr_data", ram_data_o, 32'h1234_5678);
        edge_in();
        cpu_enable = 1'b0; cpu_we = 4'h0;

        // Plugin write, then read it back.
        plg_req = 1'b1; plg_we = 1'b1; plg_addr = 32'h200; plg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("pw_we", ram_we_o, 4'hF);
        chk("pw_addr", ram_addr_o, 32'h200);
        chk("pw_data", ram_data_o, 32'hDEAD_BEEF);
        chk("pw_ready_early", plg_ready_o, 0);
        edge_in();
        @(negedge clk);
        chk("pw_no_regrant", ram_en_o, 0);
        chk("pw_ready", plg_ready_o, 1);
        edge_in();
        plg_req = 1'b0;
        @(negedge clk);
        chk("pw_ready_pulse", plg_ready_o, 0);
        plg_read(32'h200, d, lat);
        chk("pw_readback", d, 32'hDEAD_BEEF);
        chk("pr_latency", lat, LAT);

        // CPU requesting every cycle: plugin wins on the 5th cycle.
        stalls = 0;
        for (int c = 1; c <= 5 + LAT + 1; c++) begin
            edge_in();
            cpu_enable = 1'b1; cpu_addr = 32'h400;
            plg_req = (c <= 5 + LAT); plg_we = 1'b0; plg_addr = 32'h300;
            @(negedge clk);
            stalls += int'(cpu_stall_o);
            if (c == 4) chk("starve_c4_addr", ram_addr_o, 32'h400);
            if (c == 5) begin
                chk("starve_c5_stall", cpu_stall_o, 1);
                chk("starve_c5_addr", ram_addr_o, 32'h300);
            end
            if (c == 5 + LAT) begin
                chk("starve_ready", plg_ready_o, 1);
                chk("starve_rdata", plg_rdata_o, pat(32'h300));
            end
        end
        chk("starve_stall_cnt", stalls, 1);
        edge_in();
        cpu_enable = 1'b0;
        for (int i = 0; i < LAT + 1; i++) edge_in();

        // CPU read 0x10 then plugin read 0x20 on the next cycle.
        cpu_enable = 1'b1; cpu_addr = 32'h10;
        edge_in();
        cpu_enable = 1'b0; plg_req = 1'b1; plg_we = 1'b0; plg_addr = 32'h20;
        @(negedge clk);
        chk("il_plg_addr", ram_addr_o, 32'h20);
        for (int i = 0; i < LAT; i++) edge_in();
        @(negedge clk);
        chk("il_cpu_data", cpu_data_o, pat(32'h10));
        chk("il_plg_ready", plg_ready_o, 1);
        chk("il_plg_data", plg_rdata_o, pat(32'h20));
        edge_in();
        plg_req = 1'b0;

        // Reset while a plugin read is in flight.
        edge_in();
        plg_req = 1'b1; plg_we = 1'b0; plg_addr = 32'h40;
        @(negedge clk);
        chk("rr_issue", ram_en_o, 1);
        reset_n = 1'b0; cpu_enable = 1'b1; cpu_addr = 32'h44;
        rdy_seen = 0; orr = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            rdy_seen += int'(plg_ready_o);
            orr |= cpu_data_o | plg_rdata_o | ram_addr_o
                 | {26'd0, ram_en_o, ram_we_o, cpu_stall_o};
            @(negedge clk);
        end
        chk("rr_no_ready", rdy_seen, 0);
        chk("rr_outs_zero", orr, 0);
        edge_in();
        reset_n = 1'b1; cpu_enable = 1'b0; plg_req = 1'b0;
        plg_read(32'h40, d, lat);
        chk("rr_rerequest", d, pat(32'h40));
        chk("rr_latency", lat, LAT);

`ifdef PLUGIN_ADDR_CHECK_EN
        // Out-of-window plugin read: never reaches RAM, returns zero, sets error.
        edge_in();
        plg_req = 1'b1; plg_we = 1'b0; plg_addr = 32'h2_0000;
        @(negedge clk);
        chk("oow_no_ram", ram_en_o, 0);
        edge_in();
        @(negedge clk);
        chk("oow_ready", plg_ready_o, 1);
        chk("oow_rdata", plg_rdata_o, 0);
        chk("oow_err", plg_err_o, 1);
        edge_in();
        plg_req = 1'b0;
        for (int i = 0; i < 3; i++) edge_in();
        @(negedge clk);
        chk("oow_err_sticky", plg_err_o, 1);
`else
        // Without the check, 0x20000 goes to RAM (aliases word 0 of the model).
        plg_read(32'h2_0000, d, lat);
        chk("nochk_rdata", d, pat(32'h2_0000));
        chk("nochk_err", plg_err_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
